// File: rtl/nrs_ch_est_core.sv
// NB-IoT NRS channel estimator: QPSK de-rotation, N_SYM averaging, per-pilot stream.
// Define NRS_CH_EST_IIR_EN to add cross-subframe IIR smoothing of the estimates.
`timescale 1ns/1ps
module nrs_ch_est_core #(
  parameter int WIDTH_RX  = 16,
  parameter int WIDTH_EST = 17,
  parameter int N_PILOT   = 4,
  parameter int N_SYM     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sf_start,
  input  logic signed [WIDTH_RX-1:0]  rx_r,
  input  logic signed [WIDTH_RX-1:0]  rx_i,
  input  logic                        nrs_r,
  input  logic                        nrs_i,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  alpha_shift,
  input  logic                        iir_init,
  output logic signed [WIDTH_EST-1:0] h_r,
  output logic signed [WIDTH_EST-1:0] h_i,
  output logic [3:0]                  h_idx,
  output logic                        h_valid,
  input  logic                        h_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        sat
);

  localparam int L   = $clog2(N_SYM);
  localparam int PW  = WIDTH_RX + 2;
  localparam int AW  = PW + L;
  localparam int BW  = ((AW + 1 > WIDTH_EST) ? AW + 1 : WIDTH_EST) + 2;
  localparam int PCW = $clog2(N_PILOT);
  localparam int SCW = (L > 0) ? L : 1;
  localparam logic signed [BW-1:0] RND = BW'((2 ** L) / 2);
  localparam logic signed [BW-1:0] MAXB =
    {{(BW-WIDTH_EST+1){1'b0}}, {(WIDTH_EST-1){1'b1}}};
  localparam logic signed [BW-1:0] MINB =
    {{(BW-WIDTH_EST+1){1'b1}}, {(WIDTH_EST-1){1'b0}}};
  localparam logic [PCW-1:0] LAST_P = PCW'(N_PILOT - 1);
  localparam logic [SCW-1:0] LAST_S = SCW'(N_SYM - 1);

  typedef enum logic [2:0] {IDLE, ACCUM, FILT, LOAD, OUT} state_t;

  // Reaching either rail counts as a saturation event.
  function automatic logic [WIDTH_EST:0] clip(input logic signed [BW-1:0] t);
    logic                        hit;
    logic signed [WIDTH_EST-1:0] v;
    hit = (t >= MAXB) || (t <= MINB);
    if (t > MAXB)      v = MAXB[WIDTH_EST-1:0];
    else if (t < MINB) v = MINB[WIDTH_EST-1:0];
    else               v = t[WIDTH_EST-1:0];
    return {hit, v};
  endfunction

  function automatic logic [WIDTH_EST:0] avg_f(input logic signed [AW-1:0] a);
    logic signed [BW-1:0] t;
    t = (BW'(a) + RND) >>> L;
    return clip(t);
  endfunction

  state_t state_q, state_d;
  logic [PCW-1:0] pil_q;
  logic [SCW-1:0] sym_q;
  logic signed [AW-1:0] acc_r [N_PILOT];
  logic signed [AW-1:0] acc_i [N_PILOT];
  logic signed [PW-1:0] xr, xi, p_r, p_i;
  logic beat, accept, last_beat, last_out, start, load, sat_hit;
  logic [PCW-1:0] ld_idx;
  logic signed [WIDTH_EST-1:0] nx_r, nx_i;

  assign beat      = in_valid && in_ready;
  assign accept    = h_valid && h_ready;
  assign last_beat = (pil_q == LAST_P) && (sym_q == LAST_S);
  assign last_out  = h_idx == 4'(N_PILOT - 1);
  assign start     = (state_q == IDLE) && sf_start;
  assign load      = (state_q == LOAD) || (accept && !last_out);
  assign ld_idx    = (state_q == LOAD) ? '0 : PCW'(h_idx + 4'd1);

  // One guard bit: both terms can reach +2^(WIDTH_RX-1) together.
  always_comb begin
    xr  = PW'(rx_r);
    xi  = PW'(rx_i);
    p_r = (nrs_r ? -xr : xr) + (nrs_i ? -xi : xi);
    p_i = (nrs_r ? -xi : xi) - (nrs_i ? -xr : xr);
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = state_q != IDLE;
    unique case (state_q)
      IDLE: if (sf_start) state_d = ACCUM;
      ACCUM: begin
        in_ready = 1'b1;
`ifdef NRS_CH_EST_IIR_EN
        if (in_valid && last_beat) state_d = FILT;
`else
        if (in_valid && last_beat) state_d = LOAD;
`endif
      end
`ifdef NRS_CH_EST_IIR_EN
      FILT: if (pil_q == LAST_P) state_d = LOAD;
`endif
      LOAD: state_d = OUT;
      OUT: if (accept && last_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      pil_q <= '0;
      sym_q <= '0;
    end else if (beat || state_q == FILT) begin
      pil_q <= (pil_q == LAST_P) ? '0 : pil_q + 1'b1;
      if (beat && pil_q == LAST_P) sym_q <= sym_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      acc_r[pil_q] <= (sym_q == '0) ? AW'(p_r) : acc_r[pil_q] + AW'(p_r);
      acc_i[pil_q] <= (sym_q == '0) ? AW'(p_i) : acc_i[pil_q] + AW'(p_i);
    end
  end

`ifdef NRS_CH_EST_IIR_EN
  function automatic logic signed [WIDTH_EST-1:0] iir_f(
    input logic signed [WIDTH_EST-1:0] s,
    input logic signed [WIDTH_EST-1:0] a,
    input logic [2:0]                  sh
  );
    logic signed [BW-1:0] d;
    d = BW'(a) - BW'(s);
    return WIDTH_EST'(clip(BW'(s) + (d >>> sh)));
  endfunction

  logic signed [WIDTH_EST-1:0] st_r [N_PILOT];
  logic signed [WIDTH_EST-1:0] st_i [N_PILOT];
  logic st_valid, init_q, direct;
  logic [WIDTH_EST:0] fa_r, fa_i;

  assign fa_r    = avg_f(acc_r[pil_q]);
  assign fa_i    = avg_f(acc_i[pil_q]);
  assign direct  = !st_valid || init_q;
  assign sat_hit = (state_q == FILT) && (fa_r[WIDTH_EST] || fa_i[WIDTH_EST]);
  assign nx_r    = st_r[ld_idx];
  assign nx_i    = st_i[ld_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      if (start) init_q <= iir_init;
      if (state_q == FILT && pil_q == LAST_P) st_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == FILT) begin
      st_r[pil_q] <= direct ? fa_r[WIDTH_EST-1:0]
                            : iir_f(st_r[pil_q], fa_r[WIDTH_EST-1:0], alpha_shift);
      st_i[pil_q] <= direct ? fa_i[WIDTH_EST-1:0]
                            : iir_f(st_i[pil_q], fa_i[WIDTH_EST-1:0], alpha_shift);
    end
  end
`else
  logic [WIDTH_EST:0] oa_r, oa_i;
  logic unused_iir;

  assign oa_r       = avg_f(acc_r[ld_idx]);
  assign oa_i       = avg_f(acc_i[ld_idx]);
  assign sat_hit    = load && (oa_r[WIDTH_EST] || oa_i[WIDTH_EST]);
  assign nx_r       = oa_r[WIDTH_EST-1:0];
  assign nx_i       = oa_i[WIDTH_EST-1:0];
  assign unused_iir = ^{alpha_shift, iir_init};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      h_r     <= '0;
      h_i     <= '0;
      h_idx   <= '0;
      h_valid <= 1'b0;
      done    <= 1'b0;
      sat     <= 1'b0;
    end else begin
      done <= (state_q == OUT) && accept && last_out;
      if (start)        sat <= 1'b0;
      else if (sat_hit) sat <= 1'b1;
      if (load) begin
        h_r     <= nx_r;
        h_i     <= nx_i;
        h_idx   <= (state_q == LOAD) ? 4'd0 : h_idx + 4'd1;
        h_valid <= 1'b1;
      end else if (accept && last_out) begin
        h_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nrs_ch_est_core.sv
// Scoreboard bench for nrs_ch_est_core: directed windows, queued expectations.
// IIR-specific windows are built only when NRS_CH_EST_IIR_EN is defined.
`timescale 1ns/1ps
module tb_nrs_ch_est_core;
  localparam int WR = 16;
  localparam int WE = 17;
  localparam int NP = 4;
  localparam int NS = 2;
  localparam int NB = NP * NS;
`ifdef NRS_CH_EST_IIR_EN
  localparam int LAT = NP + 1;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst, sf_start, nrs_r, nrs_i, in_valid, in_ready, iir_init;
  logic h_valid, h_ready, busy, done, sat;
  logic signed [WR-1:0] rx_r, rx_i;
  logic [2:0] alpha_shift;
  logic signed [WE-1:0] h_r, h_i;
  logic [3:0] h_idx;

  always #5 clk = ~clk;

  nrs_ch_est_core #(
    .WIDTH_RX(WR), .WIDTH_EST(WE), .N_PILOT(NP), .N_SYM(NS)
  ) dut (
    .clk(clk), .rst(rst), .sf_start(sf_start),
    .rx_r(rx_r), .rx_i(rx_i), .nrs_r(nrs_r), .nrs_i(nrs_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .alpha_shift(alpha_shift), .iir_init(iir_init),
    .h_r(h_r), .h_i(h_i), .h_idx(h_idx), .h_valid(h_valid),
    .h_ready(h_ready), .busy(busy), .done(done), .sat(sat)
  );

  typedef struct {
    logic signed [WE-1:0] r;
    logic signed [WE-1:0] i;
    logic [3:0]           idx;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = -10;

  logic signed [WR-1:0] br [NB];
  logic signed [WR-1:0] bi [NB];
  logic bnr [NB];
  logic bni [NB];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int s, input int p, input int r, input int i,
                      input bit a, input bit b);
    br[s*NP+p]  = WR'(r);
    bi[s*NP+p]  = WR'(i);
    bnr[s*NP+p] = a;
    bni[s*NP+p] = b;
  endtask

  task automatic fill_all(input int r, input int i, input bit a, input bit b);
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < NP; p++) fill(s, p, r, i, a, b);
  endtask

  task automatic push(input int idx, input int r, input int i);
    exp_t e;
    e.r   = WE'(r);
    e.i   = WE'(i);
    e.idx = 4'(idx);
    q.push_back(e);
  endtask

  task automatic push_all(input int r, input int i);
    for (int p = 0; p < NP; p++) push(p, r, i);
  endtask

  task automatic send(input bit do_start, input int gap, input int nb);
    if (do_start) begin
      @(posedge clk); #1 sf_start = 1'b1;
      @(posedge clk); #1 sf_start = 1'b0;
      check("in_ready_rise", in_ready, 1);
      check("sat_clear", sat, 0);
      check("busy_accum", busy, 1);
    end
    for (int b = 0; b < nb; b++) begin
      rx_r = br[b]; rx_i = bi[b]; nrs_r = bnr[b]; nrs_i = bni[b];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (b == NB - 1) begin
        check("latency_pre", h_valid, 0);
        for (int k = 1; k <= LAT; k++) begin
          @(posedge clk); #1;
          check("latency", h_valid, (k == LAT) ? 1 : 0);
        end
      end else begin
        for (int g = 0; g < gap; g++) begin
          rx_r = 16'sh7abc; rx_i = -16'sd1234;
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    if (seen) check("done_after_accept", cyc, last_acc + 1);
    check("sb_drained", q.size(), 0);
  endtask

  // Monitor: every presented estimate is compared to the queue head.
  initial begin
    bit stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) check("stall_valid_hold", h_valid, 1);
        if (h_valid) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_estimate: got idx %0d, expected none", h_idx);
          end else begin
            check("h_idx", h_idx, q[0].idx);
            check("h_r", h_r, q[0].r);
            check("h_i", h_i, q[0].i);
            if (h_ready) begin
              if (q[0].idx == 4'(NP - 1)) last_acc = cyc;
              void'(q.pop_front());
            end
          end
        end
        stall = h_valid && !h_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sf_start = 1'b0; in_valid = 1'b0;
    rx_r = '0; rx_i = '0; nrs_r = 1'b0; nrs_i = 1'b0;
    alpha_shift = 3'd0; iir_init = 1'b0; h_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_h_valid", h_valid, 0);
    check("rst_h_r", h_r, 0);
    check("rst_h_i", h_i, 0);
    check("rst_h_idx", h_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", sat, 0);
    rst = 1'b0;

    // basic de-rotation: (100,-50)*conj(1+j) averaged over 2 symbols
    fill_all(100, -50, 0, 0);
    push_all(50, -150);
    send(1, 0, NB);
    wait_done();
    check("basic_busy_idle", busy, 0);
    check("basic_sat", sat, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // rounding and mixed reference bits, with input gaps
    fill(0, 0, 3, 0, 0, 0);    fill(1, 0, 4, 0, 0, 0);
    fill(0, 1, 3, 0, 0, 1);    fill(1, 1, 3, 0, 0, 1);
    fill(0, 2, 10, 20, 1, 1);  fill(1, 2, 10, 20, 1, 1);
    fill(0, 3, 5, -7, 1, 0);   fill(1, 3, -2, 8, 0, 1);
    push(0, 4, -3);
    push(1, 3, 3);
    push(2, -30, -10);
    push(3, -11, 4);
    send(1, 2, NB);
    wait_done();

    // largest positive average stays off the rail
    fill_all(32767, 32767, 0, 0);
    push_all(65534, 0);
    send(1, 0, NB);
    wait_done();
    check("sat_pos_clear", sat, 0);

    // most negative average lands on the rail
    fill_all(-32768, -32768, 0, 0);
    push_all(-65536, 0);
    send(1, 0, NB);
    wait_done();
    check("sat_neg_set", sat, 1);

    // backpressure, ignored sf_start and in_valid during OUT
    for (int p = 0; p < NP; p++) begin
      fill(0, p, 10 * (p + 1), 0, 0, 0);
      fill(1, p, 10 * (p + 1), 0, 0, 0);
      push(p, 10 * (p + 1), -10 * (p + 1));
    end
    h_ready = 1'b0;
    send(1, 0, NB);
    @(posedge clk); #1 sf_start = 1'b1; in_valid = 1'b1; rx_r = 16'sd999;
    @(posedge clk); #1 sf_start = 1'b0; in_valid = 1'b0; h_ready = 1'b1;
    @(posedge clk); #1 h_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 h_ready = 1'b1;
    wait_done();
    check("bp_busy_idle", busy, 0);
    @(negedge clk);
    check("bp_in_ready_idle", in_ready, 0);

    // sf_start in the done cycle, then reset mid-window
    fill_all(7, 0, 0, 0);
    push_all(7, -7);
    send(1, 0, NB);
    wait_done();
    sf_start = 1'b1;
    @(posedge clk); #1 sf_start = 1'b0;
    check("start_at_done", in_ready, 1);
    send(0, 0, 3);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_in_ready", in_ready, 0);
    check("abort_h_valid", h_valid, 0);
    check("abort_busy", busy, 0);

    alpha_shift = 3'd1;
    fill_all(50, 50, 0, 0);
    push_all(100, 0);
    send(1, 0, NB);
    wait_done();

`ifdef NRS_CH_EST_IIR_EN
    fill_all(100, 100, 0, 0);
    push_all(150, 0);
    send(1, 0, NB);
    wait_done();

    iir_init = 1'b1;
    push_all(200, 0);
    send(1, 0, NB);
    iir_init = 1'b0;
    wait_done();

    fill_all(50, 50, 0, 0);
    push_all(150, 0);
    send(1, 0, NB);
    wait_done();
`endif

    repeat (3) @(posedge clk);
    check("sb_final_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
